fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL provide parameter XLEN, default 32: instruction/PC width.
REQ-002 SHALL provide parameter DEPTH, default 4: queue entries (power of 2, >= 2).
REQ-003 SHALL provide parameter IMEM_AW, default 6: instruction-memory word-address width.
REQ-004 SHALL provide parameter RESET_PC, default 0: PC after reset.
REQ-005 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port redirect  in  1  branch/jump taken in decode; flush and reload PC.
REQ-008 SHALL have port redirect_pc  in  XLEN  redirect target.
REQ-009 SHALL have port imem_req  out  1  fetch request this cycle.
REQ-010 SHALL have port imem_addr  out  IMEM_AW  word address, pc[IMEM_AW+1:2].
REQ-011 SHALL have port imem_ready  in  1  memory accepts request; imem_rdata valid same cycle.
REQ-012 SHALL have port imem_rdata  in  XLEN  combinational read data.
REQ-013 SHALL have port out_valid  out  1  head entry valid to decode.
REQ-014 SHALL have port out_ready  in  1  decode accepts head (replaces stall input).
REQ-015 SHALL have ports instr_out, pc_out, pcplus4_out  out  XLEN each  head entry fields.
REQ-016 SHALL have port count  out  $clog2(DEPTH+1)  occupied entries.

Function
REQ-017 SHALL hold a PC register; imem_addr = pc[IMEM_AW+1:2] at all times.
REQ-018 SHALL drive imem_req = (count < DEPTH) && !redirect.
REQ-019 SHALL push on fetch = imem_req && imem_ready: entry {imem_rdata, pc, pc+4} written at tail; pc <= pc+4 next edge.
REQ-020 SHALL compute pc+4 modulo 2^XLEN (0xFFFFFFFC -> 0x00000000 for XLEN=32).
REQ-021 SHALL hold pc and queue contents when imem_ready=0 (wait states of any length).
REQ-022 SHALL drive out_valid = (count != 0) && !redirect; head fields combinational from head entry.
REQ-023 SHALL pop on out_valid && out_ready; head pointer advances next edge.
REQ-024 SHALL allow push and pop in the same cycle; count unchanged.
REQ-025 SHALL NOT push when count == DEPTH even if popping that cycle (no full-bypass); pop frees slot for next cycle.
REQ-026 SHALL NOT bypass an incoming fetch to outputs while empty; minimum fetch-to-out_valid latency is 1 cycle.
REQ-027 SHALL wrap head/tail pointers modulo DEPTH.
REQ-028 SHALL on redirect (highest priority): discard all entries (count <= 0), pc <= {redirect_pc[XLEN-1:2], 2'b00}, no push, no pop.
REQ-029 SHALL keep entry order strictly FIFO; no entry lost or duplicated outside redirect.
REQ-030 SHALL leave instr_out/pc_out/pcplus4_out don't-care while out_valid=0.

Reset
REQ-031 SHALL on reset=0, immediately and independent of clk: pc = RESET_PC, head = tail = 0, count = 0, out_valid = 0.
REQ-032 SHALL, with reset held low, drive imem_req = 1 combinationally, but SHALL perform no push.
REQ-033 SHALL discard queue and in-progress fetch when reset asserts mid-operation; first fetch after release at RESET_PC.

Verification (DEPTH=4, XLEN=32, RESET_PC=0)
REQ-034 Reset: assert reset=0 mid-stream with count=3 -> count=0, out_valid=0, imem_addr=0 without clock edge.
REQ-035 Fill: imem_ready=1, out_ready=0 for 5 cycles -> count=4 after 4th edge, imem_req=0, pc=0x10; then out_ready=1 yields pc_out 0x0,0x4,0x8,0xC in order.
REQ-036 Stream: imem_ready=1, out_ready=1 -> out_valid from cycle 2, one instruction per cycle, count stays 1.
REQ-037 Redirect: count=3, redirect=1, redirect_pc=0x43 -> out_valid=0 that cycle; next edge count=0, pc=0x40, imem_addr=0x10; next pc_out=0x40.
REQ-038 Wait: imem_ready=0 for 3 cycles at pc=0x8 -> pc holds 0x8, count unchanged; resumes on imem_ready=1.
REQ-039 Wrap: redirect_pc=0xFFFFFFFC, fetch -> pcplus4_out=0x0, next pc_out=0x0.

Source files
------------

// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a small FIFO of fetched entries.
// Holds the PC, fetches one word per cycle when the queue has room and memory
// is ready, and presents the oldest {instr, pc, pc+4} entry to decode.
// A decode redirect flushes the queue and reloads the PC, and takes priority
// over any push or pop in the same cycle.
module fetch_queue #(
  parameter int XLEN    = 32,
  parameter int DEPTH   = 4,
  parameter int IMEM_AW = 6,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       redirect,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req,
  output logic [IMEM_AW-1:0]         imem_addr,
  input  logic                       imem_ready,
  input  logic [XLEN-1:0]            imem_rdata,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [XLEN-1:0]            instr_out,
  output logic [XLEN-1:0]            pc_out,
  output logic [XLEN-1:0]            pcplus4_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0]   FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0]   ONE_C   = CW'(1'b1);
  localparam logic [CW-1:0]   ZERO_C  = {CW{1'b0}};
  localparam logic [PW-1:0]   PONE_C  = PW'(1'b1);
  localparam logic [PW-1:0]   PZERO_C = {PW{1'b0}};
  localparam logic [XLEN-1:0] FOUR_C  = XLEN'(32'd4);

  logic [XLEN-1:0] pc_r;
  logic [PW-1:0]   head_r;
  logic [PW-1:0]   tail_r;
  logic [CW-1:0]   count_r;

  logic [XLEN-1:0] instr_mem_r [DEPTH];
  logic [XLEN-1:0] pc_mem_r    [DEPTH];
  logic [XLEN-1:0] pcp4_mem_r  [DEPTH];

  logic [XLEN-1:0] pc_plus4_s;
  logic            push_s;
  logic            pop_s;
  logic [XLEN-1:0] pc_nxt_s;
  logic [PW-1:0]   head_nxt_s;
  logic [PW-1:0]   tail_nxt_s;
  logic [CW-1:0]   count_nxt_s;

  // pc+4 wraps naturally modulo 2^XLEN
  assign pc_plus4_s = pc_r + FOUR_C;

  assign imem_addr   = pc_r[IMEM_AW+1:2];
  assign count       = count_r;
  assign instr_out   = instr_mem_r[head_r];
  assign pc_out      = pc_mem_r[head_r];
  assign pcplus4_out = pcp4_mem_r[head_r];

  // Handshake decode: redirect masks both request and head-valid
  always_comb begin
    imem_req  = 1'b0;
    out_valid = 1'b0;
    if (redirect) begin
      imem_req  = 1'b0;
      out_valid = 1'b0;
    end else begin
      imem_req  = (count_r < FULL_C);
      out_valid = (count_r != ZERO_C);
    end
  end

  // Reset low still shows a request but must never commit a push
  assign push_s = imem_req && imem_ready && reset;
  assign pop_s  = out_valid && out_ready;

  // Next-state for PC, pointers and occupancy; redirect wins over everything
  always_comb begin
    pc_nxt_s    = pc_r;
    head_nxt_s  = head_r;
    tail_nxt_s  = tail_r;
    count_nxt_s = count_r;
    if (redirect) begin
      pc_nxt_s    = {redirect_pc[XLEN-1:2], 2'b00};
      head_nxt_s  = PZERO_C;
      tail_nxt_s  = PZERO_C;
      count_nxt_s = ZERO_C;
    end else begin
      if (push_s) begin
        pc_nxt_s   = pc_plus4_s;
        tail_nxt_s = tail_r + PONE_C;
      end else begin
        pc_nxt_s   = pc_r;
        tail_nxt_s = tail_r;
      end
      if (pop_s) begin
        head_nxt_s = head_r + PONE_C;
      end else begin
        head_nxt_s = head_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_nxt_s = count_r + ONE_C;
        2'b01:   count_nxt_s = count_r - ONE_C;
        default: count_nxt_s = count_r;
      endcase
    end
  end

  // Control state registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r    <= RESET_PC;
      head_r  <= PZERO_C;
      tail_r  <= PZERO_C;
      count_r <= ZERO_C;
    end else begin
      pc_r    <= pc_nxt_s;
      head_r  <= head_nxt_s;
      tail_r  <= tail_nxt_s;
      count_r <= count_nxt_s;
    end
  end

  // Entry storage: written at the tail on each accepted fetch
  always_ff @(posedge clk) begin
    if (push_s && !redirect) begin
      instr_mem_r[tail_r] <= imem_rdata;
      pc_mem_r[tail_r]    <= pc_r;
      pcp4_mem_r[tail_r]  <= pc_plus4_s;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard of expected head entries.
// A monitor pops the scoreboard on every accepted output and compares fields.
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic [31:0] pcplus4_out;
  logic [2:0]  count;

  int total;
  int bad;
  logic [31:0] exp_q [$];

  fetch_queue #(.XLEN(32), .DEPTH(4), .IMEM_AW(6), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .out_valid(out_valid), .out_ready(out_ready),
    .instr_out(instr_out), .pc_out(pc_out), .pcplus4_out(pcplus4_out),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory model: word tagged with its own word address
  assign imem_rdata = {8'h13, 18'd0, imem_addr};

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return {8'h13, 18'd0, pc[7:2]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted head entry must match the scoreboard front
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_pop: got pc 0x%08h expected no output", pc_out);
      end else begin
        logic [31:0] epc;
        epc = exp_q.pop_front();
        check("pop_pc", pc_out, epc);
        check("pop_instr", instr_out, instr_of(epc));
        check("pop_pcplus4", pcplus4_out, epc + 32'd4);
      end
    end
  end

  initial begin
    total = 0;
    bad = 0;
    reset = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    imem_ready = 1'b0;
    out_ready = 1'b0;
    #1;
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_req", {31'd0, imem_req}, 32'd1);
    check("rst_addr", {26'd0, imem_addr}, 32'd0);
    // Held in reset with memory ready: still no push
    imem_ready = 1'b1;
    step();
    step();
    check("rst_nopush", {29'd0, count}, 32'd0);
    check("rst_addr_hold", {26'd0, imem_addr}, 32'd0);

    // Fill: four fetches then full, request drops
    reset = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("fill_count", {29'd0, count}, 32'd4);
    check("fill_req", {31'd0, imem_req}, 32'd0);
    check("fill_addr", {26'd0, imem_addr}, 32'd4);
    step();
    check("full_hold", {29'd0, count}, 32'd4);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    exp_q.push_back(32'hC);
    imem_ready = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("drain_count", {29'd0, count}, 32'd0);

    // Stream: one per cycle, occupancy steady at one
    exp_q.push_back(32'h10);
    exp_q.push_back(32'h14);
    exp_q.push_back(32'h18);
    exp_q.push_back(32'h1C);
    imem_ready = 1'b1;
    check("stream_first_valid", {31'd0, out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("stream_count", {29'd0, count}, 32'd1);
      check("stream_valid", {31'd0, out_valid}, 32'd1);
    end
    imem_ready = 1'b0;
    step();
    check("stream_end", {29'd0, count}, 32'd0);

    // Wait states at pc 0x8
    out_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h8;
    step();
    redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("wait_addr", {26'd0, imem_addr}, 32'd2);
      check("wait_count", {29'd0, count}, 32'd0);
    end
    imem_ready = 1'b1;
    step();
    check("resume_count", {29'd0, count}, 32'd1);
    check("resume_addr", {26'd0, imem_addr}, 32'd3);
    step();
    step();
    check("pre_redir_count", {29'd0, count}, 32'd3);

    // Redirect with three queued entries
    imem_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h43;
    #1;
    check("redir_valid", {31'd0, out_valid}, 32'd0);
    check("redir_req", {31'd0, imem_req}, 32'd0);
    step();
    redirect = 1'b0;
    check("redir_count", {29'd0, count}, 32'd0);
    check("redir_addr", {26'd0, imem_addr}, 32'h10);
    exp_q.push_back(32'h40);
    imem_ready = 1'b1;
    out_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    step();
    check("redir_drain", {29'd0, count}, 32'd0);

    // PC wrap at top of address space
    redirect = 1'b1;
    redirect_pc = 32'hFFFFFFFC;
    step();
    redirect = 1'b0;
    check("wrap_addr", {26'd0, imem_addr}, 32'h3F);
    exp_q.push_back(32'hFFFFFFFC);
    exp_q.push_back(32'h0);
    imem_ready = 1'b1;
    step();
    check("wrap_pcplus4", pcplus4_out, 32'h0);
    step();
    imem_ready = 1'b0;
    step();
    check("wrap_end", {29'd0, count}, 32'd0);

    // Asynchronous reset mid-stream with three entries
    out_ready = 1'b0;
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check("mid_count", {29'd0, count}, 32'd3);
    reset = 1'b0;
    #1;
    check("async_count", {29'd0, count}, 32'd0);
    check("async_valid", {31'd0, out_valid}, 32'd0);
    check("async_addr", {26'd0, imem_addr}, 32'd0);
    step();
    check("async_nopush", {29'd0, count}, 32'd0);
    reset = 1'b1;
    exp_q.push_back(32'h0);
    step();
    check("post_rst_count", {29'd0, count}, 32'd1);
    imem_ready = 1'b0;
    out_ready = 1'b1;
    step();
    check("post_rst_drain", {29'd0, count}, 32'd0);
    step();
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
